// File: rtl/led_pkg.sv
// Shared types for the LED matrix scanner: frame geometry, frame buffer types
// and the scan state encoding.
package led_pkg;

  localparam int N_ROWS = 16;
  localparam int N_COLS = 16;

  typedef logic [N_COLS-1:0] row_t;
  typedef row_t [N_ROWS-1:0] frame_t;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  function automatic logic [N_ROWS-1:0] row_onehot(input logic [3:0] row);
    return {{(N_ROWS-1){1'b0}}, 1'b1} << row;
  endfunction

endpackage

// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for the 16x16 bi-colour matrix: snapshots a frame once per
// scan, then lights one row at a time with a blanking gap before every row.
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int DWELL = 2048,
  parameter int BLANK = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  frame_t      RedPixels,
  input  frame_t      GrnPixels,
  output logic [15:0] RowSink,
  output logic [15:0] RedDriver,
  output logic [15:0] GrnDriver,
  output logic        FrameStart
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  scan_state_e      state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  frame_t           red_buf_q, red_buf_d;
  frame_t           grn_buf_q, grn_buf_d;
  logic [15:0]      row_sink_q, row_sink_d;
  logic [15:0]      red_drv_q, red_drv_d;
  logic [15:0]      grn_drv_q, grn_drv_d;
  logic             frame_start_q, frame_start_d;

  // Outputs are a registered decode of the current state, so the board sees
  // each state one cycle after the FSM enters it.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    cnt_d         = cnt_q;
    red_buf_d     = red_buf_q;
    grn_buf_d     = grn_buf_q;
    row_sink_d    = '0;
    red_drv_d     = '0;
    grn_drv_d     = '0;
    frame_start_d = 1'b0;

    case (state_q)
      ST_LOAD: begin
        red_buf_d     = RedPixels;
        grn_buf_d     = GrnPixels;
        row_d         = 4'd0;
        cnt_d         = '0;
        frame_start_d = 1'b1;
        state_d       = ST_BLANK;
      end
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK - 1)) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        row_sink_d = row_onehot(row_q);
        red_drv_d  = red_buf_q[row_q];
        grn_drv_d  = grn_buf_q[row_q];
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          cnt_d = '0;
          // The last row hands over to LOAD rather than letting row wrap.
          if (row_q == 4'd15) begin
            state_d = ST_LOAD;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = ST_BLANK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_LOAD;
      row_q         <= 4'd0;
      cnt_q         <= '0;
      red_buf_q     <= '0;
      grn_buf_q     <= '0;
      row_sink_q    <= '0;
      red_drv_q     <= '0;
      grn_drv_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      red_buf_q     <= red_buf_d;
      grn_buf_q     <= grn_buf_d;
      row_sink_q    <= row_sink_d;
      red_drv_q     <= red_drv_d;
      grn_drv_q     <= grn_drv_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign RowSink    = row_sink_q;
  assign RedDriver  = red_drv_q;
  assign GrnDriver  = grn_drv_q;
  assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: frame-position reference model (cycle offset
// within the frame plus the latched snapshot) compared against the board outputs.
module tb_led_matrix_scanner;
  import led_pkg::*;

  localparam int D      = 4;
  localparam int B      = 2;
  localparam int SLOT   = B + D;
  localparam int PERIOD = 1 + N_ROWS * SLOT;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  frame_t      red_px = '0;
  frame_t      grn_px = '0;
  logic [15:0] row_sink, red_drv, grn_drv;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  // Reference model: m_t is the output cycle index inside the current frame
  // (0 = FrameStart cycle), -1 while idle in reset.
  int          m_t = -1;
  frame_t      snap_red = '0;
  frame_t      snap_grn = '0;
  logic [15:0] exp_rs, exp_red, exp_grn;
  logic        exp_fs;

  led_matrix_scanner #(.DWELL(D), .BLANK(B)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RedPixels  (red_px),
    .GrnPixels  (grn_px),
    .RowSink    (row_sink),
    .RedDriver  (red_drv),
    .GrnDriver  (grn_drv),
    .FrameStart (frame_start)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    int k, r;
    @(posedge CLK);
    if (RST) begin
      m_t = -1;
    end else if (m_t < 0 || m_t == PERIOD - 1) begin
      snap_red = red_px;
      snap_grn = grn_px;
      m_t = 0;
    end else begin
      m_t = m_t + 1;
    end
    exp_rs  = '0;
    exp_red = '0;
    exp_grn = '0;
    exp_fs  = 1'b0;
    if (m_t == 0) begin
      exp_fs = 1'b1;
    end else if (m_t > 0) begin
      k = m_t - 1;
      r = k / SLOT;
      if ((k % SLOT) >= B) begin
        exp_rs  = 16'(1) << r;
        exp_red = snap_red[r];
        exp_grn = snap_grn[r];
      end
    end
    @(negedge CLK);
  endtask

  task automatic randomize_pixels();
    for (int r = 0; r < N_ROWS; r++) begin
      red_px[r] = 16'($urandom);
      grn_px[r] = 16'($urandom);
    end
  endtask

  task automatic wait_rowsink(input logic [15:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      if (row_sink == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      if (frame_start == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({row_sink, red_drv, grn_drv, frame_start} !== 49'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rs=%h red=%h grn=%h fs=%b, required all 0",
               row_sink, red_drv, grn_drv, frame_start);
    end
    $display("test_reset: outputs rs=%h red=%h grn=%h fs=%b", row_sink, red_drv, grn_drv, frame_start);
  endtask

  task automatic test_scan_timing();
    logic [15:0] want_rs;
    randomize_pixels();
    RST = 1'b0;
    for (int c = 0; c <= PERIOD; c++) begin
      tick();
      checks++;
      if (frame_start !== ((c == 0) || (c == PERIOD))) begin
        errors++;
        $display("FAIL timing_fs c=%0d: got %b, required %b", c, frame_start, (c == 0) || (c == PERIOD));
      end
      if (c >= 1 && c <= 12) begin
        want_rs = (c >= 3 && c <= 6) ? 16'h0001 : (c >= 9 && c <= 12) ? 16'h0002 : 16'h0000;
        checks++;
        if (row_sink !== want_rs) begin
          errors++;
          $display("FAIL timing_rowsink c=%0d: got %h, required %h", c, row_sink, want_rs);
        end
      end
      checks++;
      if (row_sink !== exp_rs || red_drv !== exp_red || grn_drv !== exp_grn) begin
        errors++;
        $display("FAIL timing_model c=%0d: got rs=%h red=%h grn=%h, required rs=%h red=%h grn=%h",
                 c, row_sink, red_drv, grn_drv, exp_rs, exp_red, exp_grn);
      end
    end
    $display("test_scan_timing: %0d cycles scanned, second FrameStart=%b", PERIOD + 1, frame_start);
  endtask

  task automatic test_row5_pattern();
    bit ok;
    int lit5 = 0;
    red_px = '0;
    grn_px = '0;
    red_px[5] = 16'h07E0;
    grn_px[5] = 16'h07E0;
    wait_frame_start(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL row5_wait_fs: got timeout, required FrameStart");
    end
    for (int c = 1; c < PERIOD; c++) begin
      tick();
      if (row_sink == 16'h0020) lit5++;
      checks++;
      if (red_drv !== ((row_sink == 16'h0020) ? 16'h07E0 : 16'h0000) ||
          grn_drv !== ((row_sink == 16'h0020) ? 16'h07E0 : 16'h0000)) begin
        errors++;
        $display("FAIL row5_drivers c=%0d: got rs=%h red=%h grn=%h, required 07E0 only on rs=0020",
                 c, row_sink, red_drv, grn_drv);
      end
    end
    checks++;
    if (lit5 != D) begin
      errors++;
      $display("FAIL row5_window: got %0d lit cycles, required %0d", lit5, D);
    end
    $display("test_row5_pattern: row 5 lit for %0d cycles", lit5);
  endtask

  task automatic test_snapshot_hold();
    bit ok;
    wait_rowsink(16'h0008, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL snap_wait_row3: got timeout, required RowSink=0008");
    end
    for (int r = 0; r < N_ROWS; r++) red_px[r] = 16'hFFFF;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      if (frame_start) break;
      checks++;
      if (red_drv !== ((row_sink == 16'h0020) ? 16'h07E0 : 16'h0000)) begin
        errors++;
        $display("FAIL snap_old_data: got rs=%h red=%h, required old frame data", row_sink, red_drv);
      end
    end
    for (int c = 1; c < PERIOD; c++) begin
      tick();
      checks++;
      if (red_drv !== ((row_sink != 16'h0000) ? 16'hFFFF : 16'h0000)) begin
        errors++;
        $display("FAIL snap_new_data c=%0d: got rs=%h red=%h, required FFFF when lit", c, row_sink, red_drv);
      end
    end
    $display("test_snapshot_hold: new frame shown after reload");
  endtask

  task automatic test_reset_mid();
    bit ok;
    randomize_pixels();
    wait_rowsink(16'h0080, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_wait_row7: got timeout, required RowSink=0080");
    end
    RST = 1'b1;
    tick();
    checks++;
    if ({row_sink, red_drv, grn_drv, frame_start} !== 49'd0) begin
      errors++;
      $display("FAIL rstmid_zero: got rs=%h red=%h grn=%h fs=%b, required all 0",
               row_sink, red_drv, grn_drv, frame_start);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (frame_start !== 1'b1 || row_sink !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_fs: got fs=%b rs=%h, required fs=1 rs=0000", frame_start, row_sink);
    end
    for (int i = 0; i < B + 1; i++) tick();
    checks++;
    if (row_sink !== 16'h0001 || red_drv !== exp_red || grn_drv !== exp_grn) begin
      errors++;
      $display("FAIL rstmid_row0: got rs=%h red=%h grn=%h, required rs=0001 red=%h grn=%h",
               row_sink, red_drv, grn_drv, exp_red, exp_grn);
    end
    $display("test_reset_mid: restart row0 rs=%h red=%h", row_sink, red_drv);
  endtask

  task automatic test_reset_hold();
    int bad = 0;
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      randomize_pixels();
      tick();
      checks++;
      if ({row_sink, red_drv, grn_drv, frame_start} !== 49'd0) begin
        errors++;
        bad++;
        $display("FAIL rsthold c=%0d: got rs=%h red=%h grn=%h fs=%b, required all 0",
                 i, row_sink, red_drv, grn_drv, frame_start);
      end
    end
    RST = 1'b0;
    $display("test_reset_hold: 20 held cycles, %0d non-zero", bad);
  endtask

  task automatic test_random_frames();
    int fs_seen = 0;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      randomize_pixels();
      tick();
      if (frame_start) fs_seen++;
      checks++;
      if (!$onehot0(row_sink) || (row_sink == 16'h0000 && (red_drv != 16'h0000 || grn_drv != 16'h0000))) begin
        errors++;
        $display("FAIL rand_invariant c=%0d: got rs=%h red=%h grn=%h, required onehot0 and dark drivers",
                 c, row_sink, red_drv, grn_drv);
      end
      checks++;
      if (row_sink !== exp_rs || red_drv !== exp_red || grn_drv !== exp_grn || frame_start !== exp_fs) begin
        errors++;
        $display("FAIL rand_model c=%0d: got rs=%h red=%h grn=%h fs=%b, required rs=%h red=%h grn=%h fs=%b",
                 c, row_sink, red_drv, grn_drv, frame_start, exp_rs, exp_red, exp_grn, exp_fs);
      end
    end
    $display("test_random_frames: %0d cycles, %0d FrameStart pulses", 3 * PERIOD, fs_seen);
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_row5_pattern();
    test_snapshot_hold();
    test_reset_mid();
    test_reset_hold();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Row-scanning driver for the 16x16 bi-colour LED matrix. It takes the full-frame RedPixels/GrnPixels arrays from the pattern/game logic and snapshots them once per frame. It then time-multiplexes the frame onto the physical board, lighting one row at a time with per-row blanking to suppress ghosting. It sits directly downstream of the pattern generators and directly drives the board pins.

## Interface
- DWELL, default 2048: clock cycles each row is lit; legal range ≥ 1.
- BLANK, default 64: clock cycles all outputs are off before each row; legal range ≥ 1.
- CLK  in  1  system clock; all logic is rising-edge.
- RST  in  1  reset; synchronous, active-high.
- RedPixels  in  [15:0][15:0]  source frame, red plane; RedPixels[r][c] = row r, column c, 1 = on.
- GrnPixels  in  [15:0][15:0]  source frame, green plane; same indexing.
- RowSink  out  16  one-hot row enable, active-high; bit r selects row r.
- RedDriver  out  16  red column data for the selected row; bit c = column c.
- GrnDriver  out  16  green column data for the selected row.
- FrameStart  out  1  one-cycle pulse marking the snapshot of a new frame.

## Operation
- Internal frame buffer: two 16x16 planes, loaded only in LOAD. Input changes between loads have no visible effect until the next frame.
- FSM has three states: LOAD, BLANK, SHOW.
- Internal counters: row index (4 bits) and dwell counter, width $clog2(max(DWELL,BLANK)+1).
- LOAD lasts exactly 1 cycle. It copies both input planes into the buffer, clears row to 0 and the counter to 0, pulses FrameStart, then moves to BLANK.
- BLANK lasts exactly BLANK cycles. RowSink, RedDriver and GrnDriver are all 0. Then it clears the counter and moves to SHOW.
- SHOW lasts exactly DWELL cycles:
  - RowSink = 16'h0001 << row.
  - RedDriver = buffer red[row]; GrnDriver = buffer green[row].
  - At the end: if row == 15, go to LOAD. Otherwise increment row and go to BLANK.
- Exactly one RowSink bit is high in SHOW; no RowSink bit is high in any other state.
- Row index never wraps through arithmetic overflow. The transition from row 15 always goes through LOAD.
- Reset values: RowSink = 0, RedDriver = 0, GrnDriver = 0, FrameStart = 0. State = LOAD, row = 0, counter = 0, buffer = all 0.
- Reset mid-frame: the cycle after the edge that samples RST = 1, all outputs are 0. The partial frame is abandoned and the frame restarts from LOAD after RST drops.
- While RST is held, no LOAD occurs and FrameStart stays 0.

## Timing
- All outputs are registered; they are glitch-free and change only on the rising edge of CLK.
- Output cycle 0 is the first cycle after the first edge with RST = 0.
  - Cycle 0: FrameStart = 1, all drive outputs = 0.
  - Cycles 1..BLANK: blank.
  - Next DWELL cycles: row 0 lit.
  - Each further row repeats the pattern of BLANK blank cycles, then DWELL lit cycles.
- Frame period = 1 + 16×(BLANK + DWELL) cycles. FrameStart pulses are spaced exactly one frame period apart.
- Inputs are sampled only on the LOAD edge. Capture latency from input to first display of row 0 = 1 + BLANK cycles.
- The row 15 → LOAD → row 0 boundary has 1 + BLANK blank cycles; every other row boundary has exactly BLANK.

## Structure
- Shared package led_pkg holds:
  - N_ROWS = 16, N_COLS = 16.
  - typedef logic [N_COLS-1:0] row_t.
  - typedef row_t [N_ROWS-1:0] frame_t, used for the pixel ports and the buffer.
  - The scan state enum (LOAD, BLANK, SHOW).
- No sub-module. The FSM, counters and buffer live in a single module.

## Test plan
- Reset then release, DWELL = 4, BLANK = 2: FrameStart at cycle 0 only. Zeros in cycles 1–2. RowSink = 0x0001 in cycles 3–6. Zeros in cycles 7–8. RowSink = 0x0002 in cycles 9–12. Next FrameStart at cycle 97.
- Red row 5 = 0x07E0, green row 5 = 0x07E0, all other rows 0: during the row 5 SHOW window, Red/GrnDriver = 0x07E0 and RowSink = 0x0020. Drivers = 0 in every other window.
- Change RedPixels to all ones while row 3 is lit: rows 4–15 still show the old data. The next frame shows 0xFFFF on every row.
- Assert RST for 1 cycle during row 7 SHOW: all outputs are 0 on the next cycle. FrameStart fires 1 cycle after RST drops, then row 0 is displayed.
- Hold RST for 20 cycles: outputs and FrameStart stay 0 throughout.
- Run 3 frames with random pixels and check every cycle: RowSink is one-hot or zero, the drivers are 0 whenever RowSink is 0, and displayed data equals the frame snapshot taken at the last FrameStart.
